adder_bist_ctrl: RTL and testbench

- Built-in self-test controller for the team's 32-bit ripple-carry adder netlists (full adder and sensitized single-path variants).
- Drives pseudo-random operands into the adder under test and compacts its sum/carry responses into a MISR signature.
- Compares that signature with a golden value and reports pass/fail.
- Sits between the ATPG/test wrapper (which issues start, golden and reads results) and the combinational DUT.

---
 rtl/adder_bist_pkg.sv | 37 +++
 rtl/bist_lfsr32.sv | 27 ++
 rtl/adder_bist_ctrl.sv | 160 ++++++++++++++++
 tb/tb_adder_bist_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_bist_pkg.sv
// Purpose: shared types, polynomial and path-delay vectors for the adder BIST controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adder_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    APPLY,
    DRAIN,
    COMPARE,
    DONE
  } bist_state_t;

  // Galois tap mask for x^32+x^22+x^2+x+1, used by both LFSRs and the MISR.
  localparam logic [31:0] LFSR_POLY32 = 32'h8020_0003;

  // Launch/capture vectors that sensitize the full carry chain a0 -> s31.
  localparam logic [31:0] PD_A_LAUNCH  = 32'h0000_0000;
  localparam logic [31:0] PD_A_CAPTURE = 32'h0000_0001;
  localparam logic [31:0] PD_B         = 32'hFFFF_FFFF;
  localparam logic        PD_CIN       = 1'b0;
  localparam logic [15:0] PD_NUM_APPLY = 16'd2;
  localparam logic [15:0] PD_NUM_CAPT  = 16'd1;

  function automatic logic [31:0] lfsr32_next(input logic [31:0] cur);
    lfsr32_next = (cur >> 1) ^ (cur[0] ? LFSR_POLY32 : 32'h0);
  endfunction

  function automatic logic [31:0] misr32_next(input logic [31:0] sig,
                                              input logic [31:0] resp,
                                              input logic        cout);
    misr32_next = {sig[0], sig[31:1]} ^ (sig[0] ? LFSR_POLY32 : 32'h0)
                  ^ resp ^ {31'b0, cout};
  endfunction

endpackage

// File: rtl/bist_lfsr32.sv
// Purpose: 32-bit right-shifting Galois LFSR pattern source with seed load and step enable.
// Latency: new value visible the cycle after load/step; holds otherwise.
// Backpressure: none; the caller gates step.
// Ports: clk, rst_n (async, active-low), load (reload SEED), step (advance one state), lfsr (current value).
module bist_lfsr32
  import adder_bist_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [31:0] lfsr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (load) begin
      lfsr <= SEED;
    end else if (step) begin
      lfsr <= lfsr32_next(lfsr);
    end
  end

endmodule

// File: rtl/adder_bist_ctrl.sv
// Purpose: BIST controller for a 32-bit ripple-carry adder: LFSR operands in, MISR-compacted responses, golden compare.
// Latency: done rises NUM_PATTERNS+CAPTURE_LAT+2 cycles after start is accepted.
// Backpressure: none; start is ignored while busy, accepted in IDLE or DONE.
// Ports: clk, rst_n, start, golden in; dut_a/dut_b/dut_cin to the adder; dut_sum/dut_cout back;
//        busy, done, pass, signature status. Optional macro BIST_PATH_DELAY_EN adds pd_mode
//        (sampled with start) selecting a launch/capture path-delay run instead of the MISR run.
module adder_bist_ctrl
  import adder_bist_pkg::*;
#(
  parameter int          WIDTH        = 32,   // only 32 is meaningful for these polynomials
  parameter int          NUM_PATTERNS = 256,  // 1..65535
  parameter int          CAPTURE_LAT  = 1,    // 1..4
  parameter logic [31:0] SEED_A       = 32'h0000_0001,
  parameter logic [31:0] SEED_B       = 32'hFFFF_FFFF,
  parameter logic [31:0] MISR_SEED    = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] golden,
`ifdef BIST_PATH_DELAY_EN
  input  logic             pd_mode,
`endif
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature
);

  localparam logic [15:0] NPAT = 16'(NUM_PATTERNS);

  bist_state_t            state, state_nxt;
  logic [15:0]            app_cnt, cap_cnt, cap_cnt_nxt;
  logic [15:0]            n_app, n_cap;
  logic [CAPTURE_LAT-1:0] cap_dly, cap_dly_nxt;
  logic                   inject, cap_en, misr_en, cmp_ok, start_ok;
  logic                   lfsr_load, lfsr_step;
  logic [31:0]            lfsr_a, lfsr_b;

  assign lfsr_load = (state == SEED);
  assign lfsr_step = (state == APPLY);
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  bist_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .step (lfsr_step),
    .lfsr (lfsr_a)
  );

  bist_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .step (lfsr_step),
    .lfsr (lfsr_b)
  );

`ifdef BIST_PATH_DELAY_EN
  logic pd_run;   // current/last run is a path-delay run
  logic pd_vec1;  // launch vector has been applied, capture vector now on the bus
  logic pd_ok;    // captured response of the capture vector was sum==0, cout==1

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pd_run  <= 1'b0;
      pd_vec1 <= 1'b0;
      pd_ok   <= 1'b0;
    end else begin
      if (start_ok) pd_run <= pd_mode;
      if (state == SEED) begin
        pd_vec1 <= 1'b0;
        pd_ok   <= 1'b0;
      end else begin
        if (state == APPLY) pd_vec1 <= 1'b1;
        if (cap_en && pd_run) pd_ok <= (dut_sum == '0) && dut_cout;
      end
    end
  end

  assign n_app   = pd_run ? PD_NUM_APPLY : NPAT;
  assign n_cap   = pd_run ? PD_NUM_CAPT : NPAT;
  // Only the second (capture) vector's response is of interest in a path-delay run.
  assign inject  = (state == APPLY) && (!pd_run || (app_cnt == PD_NUM_APPLY - 16'd1));
  assign misr_en = cap_en && !pd_run;
  assign cmp_ok  = pd_run ? pd_ok : (signature == golden);
  assign dut_a   = pd_run ? (pd_vec1 ? PD_A_CAPTURE : PD_A_LAUNCH) : lfsr_a;
  assign dut_b   = pd_run ? PD_B : lfsr_b;
  assign dut_cin = pd_run ? PD_CIN : (lfsr_a[0] ^ lfsr_b[31]);
`else
  assign n_app   = NPAT;
  assign n_cap   = NPAT;
  assign inject  = (state == APPLY);
  assign misr_en = cap_en;
  assign cmp_ok  = (signature == golden);
  assign dut_a   = lfsr_a;
  assign dut_b   = lfsr_b;
  assign dut_cin = lfsr_a[0] ^ lfsr_b[31];
`endif

  // Delay line: bit i set means a vector driven i+1 cycles ago is owed a capture.
  // The oldest bit marks the cycle whose dut_sum/dut_cout the MISR absorbs.
  assign cap_en = cap_dly[CAPTURE_LAT-1];

  always_comb begin
    cap_dly_nxt    = cap_dly << 1;
    cap_dly_nxt[0] = inject;
  end

  assign cap_cnt_nxt = cap_cnt + {15'b0, cap_en};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      app_cnt   <= '0;
      cap_cnt   <= '0;
      cap_dly   <= '0;
      signature <= MISR_SEED;
      pass      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == SEED) begin
        app_cnt   <= '0;
        cap_cnt   <= '0;
        cap_dly   <= '0;
        signature <= MISR_SEED;
        pass      <= 1'b0;
      end else begin
        if (state == APPLY) app_cnt <= app_cnt + 16'd1;
        cap_dly <= cap_dly_nxt;
        cap_cnt <= cap_cnt_nxt;
        if (misr_en) signature <= misr32_next(signature, dut_sum, dut_cout);
        if (state == COMPARE) pass <= cmp_ok;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_ok) state_nxt = SEED;
      SEED:       state_nxt = APPLY;
      APPLY:      if (app_cnt == n_app - 16'd1) state_nxt = DRAIN;
      // Leave on the cycle of the final capture so COMPARE sees the finished signature.
      DRAIN:      if (cap_cnt_nxt == n_cap) state_nxt = COMPARE;
      COMPARE:    state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SEED) || (state == APPLY) || (state == DRAIN) || (state == COMPARE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Purpose: self-checking bench for adder_bist_ctrl with behavioural adder models and a software signature model.
// Latency: n/a.
// Backpressure: n/a.
module tb_adder_bist_ctrl;

  localparam logic [31:0] POLY  = 32'h8020_0003;
  localparam logic [31:0] SA    = 32'h0000_0001;
  localparam logic [31:0] SB    = 32'hFFFF_FFFF;
  localparam int          N0    = 256;
  localparam int          L0    = 1;
  localparam int          N1    = 1;
  localparam int          L1    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [31:0] golden0, golden1;
  logic [31:0] a0, b0, sum0, sig0, a1, b1, sum1, sig1;
  logic        cin0, cout0, busy0, done0, pass0;
  logic        cin1, cout1, busy1, done1, pass1;
`ifdef BIST_PATH_DELAY_EN
  logic        pd_mode0, pd_mode1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adder_bist_ctrl #(.NUM_PATTERNS(N0), .CAPTURE_LAT(L0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .golden(golden0),
`ifdef BIST_PATH_DELAY_EN
    .pd_mode(pd_mode0),
`endif
    .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_sum(sum0), .dut_cout(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  adder_bist_ctrl #(.NUM_PATTERNS(N1), .CAPTURE_LAT(L1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .golden(golden1),
`ifdef BIST_PATH_DELAY_EN
    .pd_mode(pd_mode1),
`endif
    .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_sum(sum1), .dut_cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  // Adder under test for u0: one register stage, optional s31 stuck-at-0 or s31 one cycle late.
  logic        stuck_s31 = 1'b0;
  logic        late_s31  = 1'b0;
  logic [32:0] add0, add1;
  logic [31:0] m0_s;
  logic        m0_co, m0_late;
  assign add0 = {1'b0, a0} + {1'b0, b0} + {32'b0, cin0};
  always @(posedge clk) begin
    m0_s    <= stuck_s31 ? {1'b0, add0[30:0]} : add0[31:0];
    m0_co   <= add0[32];
    m0_late <= m0_s[31];
  end
  assign sum0  = {late_s31 ? m0_late : m0_s[31], m0_s[30:0]};
  assign cout0 = m0_co;

  // Adder under test for u1: three register stages.
  logic [32:0] p1 [3];
  assign add1 = {1'b0, a1} + {1'b0, b1} + {32'b0, cin1};
  always @(posedge clk) begin
    p1[0] <= add1;
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign sum1  = p1[2][31:0];
  assign cout1 = p1[2][32];

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] lfsr_after(input logic [31:0] seed, input int n);
    logic [31:0] v;
    v = seed;
    for (int k = 0; k < n; k++) v = lfsr_next(v);
    return v;
  endfunction

  // Signature the fault-free (or s31-stuck) adder should leave after n vectors.
  function automatic logic [31:0] model_sig(input int n, input bit stuck);
    logic [31:0] a, b, s, sig;
    logic [32:0] t;
    a = SA; b = SB; sig = 32'h0;
    for (int k = 0; k < n; k++) begin
      t = {1'b0, a} + {1'b0, b} + {32'b0, a[0] ^ b[31]};
      s = t[31:0];
      if (stuck) s[31] = 1'b0;
      sig = ((sig >> 1) | (sig << 31)) ^ (sig[0] ? POLY : 32'h0) ^ s ^ {31'b0, t[32]};
      a = lfsr_next(a);
      b = lfsr_next(b);
    end
    return sig;
  endfunction

  logic [31:0] a_log [0:299];
  logic        busy_at0;

  // Pulse start (accepted at the next rising edge, cycle 0) and return n = cycle in which done
  // is first seen. Extra start pulses are raised in cycles g1/g2; reset is asserted at cycle rst_at.
  task automatic run(input int inst, input int budget, input int g1, input int g2,
                     input int rst_at, output int n);
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (inst == 0) start0 = 1'b0; else start1 = 1'b0;
    n = 0;
    while (1) begin
      if (inst == 0 && n < 300) a_log[n] = a0;
      if (n == 0) busy_at0 = (inst == 0) ? busy0 : busy1;
      if (n == rst_at) begin
        rst_n = 1'b0;
        return;
      end
      if (((inst == 0) ? done0 : done1) || n >= budget) break;
      @(negedge clk);
      n++;
      if (inst == 0) start0 = (n == g1) || (n == g2);
      else start1 = (n == g1) || (n == g2);
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total++; if (a0 !== SA) begin bad++; $display("FAIL reset_a got %h want %h", a0, SA); end
    total++; if (b0 !== SB) begin bad++; $display("FAIL reset_b got %h want %h", b0, SB); end
    total++; if (cin0 !== 1'b0) begin bad++; $display("FAIL reset_cin got %b want 0", cin0); end
    total++; if ({busy0, done0, pass0} !== 3'b000) begin bad++; $display("FAIL reset_flags got %b want 000", {busy0, done0, pass0}); end
    total++; if (sig0 !== 32'h0) begin bad++; $display("FAIL reset_sig got %h want 0", sig0); end
    total++; if ({busy1, done1, pass1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got %b want 000", {busy1, done1, pass1}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fault_free;
    int n, errs;
    golden0 = model_sig(N0, 1'b0);
    run(0, 400, -1, -1, -1, n);
    total++; if (n !== N0 + L0 + 2) begin bad++; $display("FAIL ff_done_cycle got %0d want %0d", n, N0 + L0 + 2); end
    total++; if (busy_at0 !== 1'b1) begin bad++; $display("FAIL ff_busy_early got %b want 1", busy_at0); end
    total++; if ({done0, busy0, pass0} !== 3'b101) begin bad++; $display("FAIL ff_flags got %b want 101", {done0, busy0, pass0}); end
    total++; if (sig0 !== golden0) begin bad++; $display("FAIL ff_sig got %h want %h", sig0, golden0); end
    total++; if (a_log[2] !== 32'h8020_0003) begin bad++; $display("FAIL ff_second_a got %h want 80200003", a_log[2]); end
    errs = 0;
    for (int k = 0; k < N0; k++) if (a_log[k + 1] !== lfsr_after(SA, k)) errs++;
    total++; if (errs != 0) begin bad++; $display("FAIL ff_a_sequence got %0d wrong vectors want 0", errs); end
    total++; if (a0 !== lfsr_after(SA, N0)) begin bad++; $display("FAIL ff_a_hold got %h want %h", a0, lfsr_after(SA, N0)); end
  endtask

  task automatic test_stuck;
    int n;
    stuck_s31 = 1'b1;
    golden0 = model_sig(N0, 1'b0);
    run(0, 400, -1, -1, -1, n);
    total++; if ({done0, pass0} !== 2'b10) begin bad++; $display("FAIL stuck_flags got %b want 10", {done0, pass0}); end
    total++; if (sig0 !== model_sig(N0, 1'b1)) begin bad++; $display("FAIL stuck_sig got %h want %h", sig0, model_sig(N0, 1'b1)); end
    stuck_s31 = 1'b0;
  endtask

  task automatic test_back_to_back;
    int n;
    bit corrupt;
    for (int i = 0; i < 3; i++) begin
      corrupt = ($urandom_range(0, 1) == 1);
      golden0 = model_sig(N0, 1'b0) ^ (corrupt ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
      run(0, 400, -1, -1, -1, n);
      total++; if (pass0 !== !corrupt) begin bad++; $display("FAIL b2b_pass[%0d] got %b want %b", i, pass0, !corrupt); end
    end
  endtask

  task automatic test_start_ignored;
    int n;
    golden0 = model_sig(N0, 1'b0);
    run(0, 400, 5, 100, -1, n);
    total++; if (n !== N0 + L0 + 2) begin bad++; $display("FAIL ign_done_cycle got %0d want %0d", n, N0 + L0 + 2); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL ign_pass got %b want 1", pass0); end
  endtask

  task automatic test_reset_midrun;
    int n;
    golden0 = model_sig(N0, 1'b0);
    run(0, 400, -1, -1, 50, n);
    #1;
    total++; if ({busy0, done0, pass0} !== 3'b000) begin bad++; $display("FAIL mid_flags got %b want 000", {busy0, done0, pass0}); end
    total++; if (a0 !== SA || b0 !== SB) begin bad++; $display("FAIL mid_ops got %h/%h want %h/%h", a0, b0, SA, SB); end
    total++; if (sig0 !== 32'h0) begin bad++; $display("FAIL mid_sig got %h want 0", sig0); end
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 400, -1, -1, -1, n);
    total++; if (n !== N0 + L0 + 2) begin bad++; $display("FAIL mid_rerun_cycle got %0d want %0d", n, N0 + L0 + 2); end
    total++; if (pass0 !== 1'b1) begin bad++; $display("FAIL mid_rerun_pass got %b want 1", pass0); end
  endtask

  task automatic test_lat3;
    int n;
    golden1 = model_sig(N1, 1'b0);
    run(1, 50, -1, -1, -1, n);
    total++; if (n !== N1 + L1 + 2) begin bad++; $display("FAIL lat3_done_cycle got %0d want %0d", n, N1 + L1 + 2); end
    total++; if (pass1 !== 1'b1) begin bad++; $display("FAIL lat3_pass got %b want 1", pass1); end
    total++; if (sig1 !== golden1) begin bad++; $display("FAIL lat3_sig got %h want %h", sig1, golden1); end
  endtask

`ifdef BIST_PATH_DELAY_EN
  task automatic test_path_delay;
    int n;
    pd_mode0 = 1'b1;
    golden0 = $urandom;
    run(0, 50, -1, -1, -1, n);
    total++; if ({done0, pass0} !== 2'b11) begin bad++; $display("FAIL pd_good got %b want 11", {done0, pass0}); end
    total++; if (sig0 !== 32'h0) begin bad++; $display("FAIL pd_sig_frozen got %h want 0", sig0); end
    total++; if (a0 !== 32'h1 || b0 !== 32'hFFFF_FFFF || cin0 !== 1'b0) begin bad++; $display("FAIL pd_vec got %h/%h/%b want 1/ffffffff/0", a0, b0, cin0); end
    late_s31 = 1'b1;
    run(0, 50, -1, -1, -1, n);
    total++; if ({done0, pass0} !== 2'b10) begin bad++; $display("FAIL pd_slow got %b want 10", {done0, pass0}); end
    late_s31 = 1'b0;
    pd_mode0 = 1'b0;
    golden0 = model_sig(N0, 1'b0);
    run(0, 400, -1, -1, -1, n);
    total++; if (pass0 !== 1'b1 || n !== N0 + L0 + 2) begin bad++; $display("FAIL pd_off_run got pass=%b n=%0d want pass=1 n=%0d", pass0, n, N0 + L0 + 2); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    golden0 = 32'h0; golden1 = 32'h0;
`ifdef BIST_PATH_DELAY_EN
    pd_mode0 = 1'b0; pd_mode1 = 1'b0;
`endif
    test_reset();
    test_fault_free();
    test_stuck();
    test_back_to_back();
    test_start_ignored();
    test_reset_midrun();
    test_lat3();
`ifdef BIST_PATH_DELAY_EN
    test_path_delay();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
